// File: rtl/mdr_pkg.sv
// Shared types, constants and helpers for the multi-digit crossing-feature recognizer.
package mdr_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LUT_N  = 10;

    localparam logic [ID_W-1:0] ID_UNKNOWN = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_CLASS = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Per-box crossing feature, MSB first as it appears in the lookup table.
    typedef struct packed {
        logic             x1_l;
        logic             x1_r;
        logic             x2_l;
        logic             x2_r;
        logic [CNT_W-1:0] y;
        logic [CNT_W-1:0] x1;
        logic [CNT_W-1:0] x2;
    } feat_s;

    localparam int unsigned FEAT_W = $bits(feat_s);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            unknown;
    } class_res_s;

    // Entry i holds the feature that classifies as digit i.
    localparam logic [LUT_N-1:0][FEAT_W-1:0] LUT_FEAT = {
        16'hD321, 16'hF322, 16'h6211, 16'hB312, 16'h9311,
        16'hD221, 16'h5311, 16'h6311, 16'hA111, 16'hF222
    };

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mdr_feature_lut.sv
// Combinational feature -> {digit id, unknown} lookup shared by all boxes.
module mdr_feature_lut
    import mdr_pkg::*;
(
    input  logic [FEAT_W-1:0] feat_i,
    input  logic              degenerate_i,
    output class_res_s        res_c_o
);

    always_comb begin
        res_c_o.id      = ID_UNKNOWN;
        res_c_o.unknown = 1'b1;
        if (!degenerate_i) begin
            for (int unsigned i = 0; i < LUT_N; i++) begin
                if (feat_i == LUT_FEAT[i]) begin
                    res_c_o.id      = ID_W'(i);
                    res_c_o.unknown = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/multi_digit_recognizer.sv
// Crossing-feature classifier for NUM_DIGITS boxes per frame on the TFT pixel stream.
// Define MDR_FEATURE_DEBUG_EN to expose the snapshot features on o_features.
module multi_digit_recognizer
    import mdr_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CW         = 12,
    parameter int unsigned ROW1_NUM   = 3,
    parameter int unsigned ROW2_NUM   = 5,
    parameter int unsigned EVAL_FRAME = 1
) (
    input  logic                       TFT_VCLK,
    input  logic                       rst_n,
    input  logic [2:0]                 frame_cnt,
    input  logic [23:0]                i_rgb,
    input  logic                       i_vsync,
    input  logic                       i_de,
    input  logic [CW-1:0]              hcount,
    input  logic [CW-1:0]              vcount,
    input  logic [NUM_DIGITS*CW-1:0]   box_l,
    input  logic [NUM_DIGITS*CW-1:0]   box_r,
    input  logic [NUM_DIGITS*CW-1:0]   box_t,
    input  logic [NUM_DIGITS*CW-1:0]   box_b,
    output logic [NUM_DIGITS*ID_W-1:0] o_digit_ids,
    output logic [NUM_DIGITS-1:0]      o_unknown,
    output logic                       o_valid,
    output logic                       o_busy,
    output logic                       o_overrun
`ifdef MDR_FEATURE_DEBUG_EN
    ,
    output logic [NUM_DIGITS*FEAT_W-1:0] o_features
`endif
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW1   = CW + 1;
    localparam int unsigned PW    = CW + 4;

    state_e                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic                              vs_q, fg_q;
    logic                              vs_rise, fg, start_eval, acc_clr, acc_hold;
    logic                              snap_en, class_en;
    logic                              valid_q, valid_d;
    logic                              busy_q, busy_d;
    logic                              overrun_q, overrun_d;
    logic [NUM_DIGITS-1:0][FEAT_W-1:0] feat_acc, snap_q;
    logic [NUM_DIGITS-1:0]             deg_frame, snap_deg_q, unk_q;
    logic [NUM_DIGITS-1:0][ID_W-1:0]   ids_q;
    class_res_s                        lut_res;

    assign vs_rise    = i_vsync & ~vs_q;
    assign fg         = i_de & (|i_rgb);
    assign start_eval = vs_rise && (state_q == ST_IDLE) && (frame_cnt == 3'(EVAL_FRAME));
    // Accumulators survive the evaluating VS edge so SNAP can copy them next cycle.
    assign acc_hold   = start_eval;
    assign acc_clr    = (vs_rise & ~start_eval) | snap_en;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_box
        logic [CW-1:0]    in_l, in_r, in_t, in_b, h_d, cx_d, y1_d, y2_d;
        logic [PW-1:0]    prod1, prod2;
        logic             deg_d;
        logic [CW-1:0]    l_q, r_q, t_q, b_q, cx_q, y1_q, y2_q;
        logic             deg_q, deg_prev_q;
        logic [CNT_W-1:0] x1_q, x2_q, y_q;
        logic             x1l_q, x1r_q, x2l_q, x2r_q, vprev_q;
        logic             in_h, in_v, on_r1, on_r2, on_c, left, cross_h, cross_v;

        assign in_l  = box_l[k*CW +: CW];
        assign in_r  = box_r[k*CW +: CW];
        assign in_t  = box_t[k*CW +: CW];
        assign in_b  = box_b[k*CW +: CW];
        assign h_d   = in_b - in_t;
        assign prod1 = PW'(h_d) * PW'(ROW1_NUM);
        assign prod2 = PW'(h_d) * PW'(ROW2_NUM);
        assign cx_d  = in_l + ((in_r - in_l) >> 1);
        assign y1_d  = in_t + CW'(prod1 >> 3);
        assign y2_d  = in_t + CW'(prod2 >> 3);
        assign deg_d = ({1'b0, in_r} < ({1'b0, in_l} + CW1'(2))) ||
                       ({1'b0, in_b} < ({1'b0, in_t} + CW1'(3)));

        assign in_h    = (hcount >= l_q) && (hcount <= r_q);
        assign in_v    = (vcount >= t_q) && (vcount <= b_q);
        assign on_r1   = i_de && in_h && (vcount == y1_q);
        assign on_r2   = i_de && in_h && (vcount == y2_q);
        assign on_c    = i_de && in_v && (hcount == cx_q);
        assign left    = hcount < cx_q;
        assign cross_h = fg && ((hcount == l_q) || !fg_q);
        assign cross_v = fg && ((vcount == t_q) || !vprev_q);

        // Geometry of the frame being accumulated; deg_prev_q belongs to the frame just ended.
        always_ff @(posedge TFT_VCLK or negedge rst_n) begin
            if (!rst_n) begin
                l_q        <= '0;
                r_q        <= '0;
                t_q        <= '0;
                b_q        <= '0;
                cx_q       <= '0;
                y1_q       <= '0;
                y2_q       <= '0;
                deg_q      <= 1'b1;
                deg_prev_q <= 1'b1;
            end else if (vs_rise) begin
                l_q        <= in_l;
                r_q        <= in_r;
                t_q        <= in_t;
                b_q        <= in_b;
                cx_q       <= cx_d;
                y1_q       <= y1_d;
                y2_q       <= y2_d;
                deg_q      <= deg_d;
                deg_prev_q <= deg_q;
            end
        end

        always_ff @(posedge TFT_VCLK or negedge rst_n) begin
            if (!rst_n) begin
                x1_q    <= '0;
                x2_q    <= '0;
                y_q     <= '0;
                x1l_q   <= 1'b0;
                x1r_q   <= 1'b0;
                x2l_q   <= 1'b0;
                x2r_q   <= 1'b0;
                vprev_q <= 1'b0;
            end else if (acc_clr) begin
                x1_q    <= '0;
                x2_q    <= '0;
                y_q     <= '0;
                x1l_q   <= 1'b0;
                x1r_q   <= 1'b0;
                x2l_q   <= 1'b0;
                x2r_q   <= 1'b0;
                vprev_q <= 1'b0;
            end else if (!acc_hold) begin
                if (on_r1) begin
                    if (cross_h) x1_q <= sat_inc(x1_q);
                    if (fg && left) x1l_q <= 1'b1;
                    if (fg && !left) x1r_q <= 1'b1;
                end
                if (on_r2) begin
                    if (cross_h) x2_q <= sat_inc(x2_q);
                    if (fg && left) x2l_q <= 1'b1;
                    if (fg && !left) x2r_q <= 1'b1;
                end
                if (on_c) begin
                    vprev_q <= fg;
                    if (cross_v) y_q <= sat_inc(y_q);
                end
            end
        end

        assign feat_acc[k]  = {x1l_q, x1r_q, x2l_q, x2r_q, y_q, x1_q, x2_q};
        assign deg_frame[k] = deg_prev_q;
    end

    mdr_feature_lut u_lut (
        .feat_i       (snap_q[idx_q]),
        .degenerate_i (snap_deg_q[idx_q]),
        .res_c_o      (lut_res)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_en   = 1'b0;
        class_en  = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (start_eval) state_d = ST_SNAP;
            end
            ST_SNAP: begin
                snap_en = 1'b1;
                idx_d   = '0;
                state_d = ST_CLASS;
            end
            ST_CLASS: begin
                class_en = 1'b1;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        if (vs_rise && (state_q != ST_IDLE)) overrun_d = 1'b1;
    end

    always_ff @(posedge TFT_VCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            vs_q       <= 1'b0;
            fg_q       <= 1'b0;
            snap_q     <= '0;
            snap_deg_q <= '1;
            ids_q      <= '1;
            unk_q      <= '1;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vs_q      <= i_vsync;
            fg_q      <= fg;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            if (snap_en) begin
                snap_q     <= feat_acc;
                snap_deg_q <= deg_frame;
            end
            if (class_en) begin
                ids_q[idx_q] <= lut_res.id;
                unk_q[idx_q] <= lut_res.unknown;
            end
        end
    end

    assign o_digit_ids = ids_q;
    assign o_unknown   = unk_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_overrun   = overrun_q;
`ifdef MDR_FEATURE_DEBUG_EN
    assign o_features  = snap_q;
`endif

endmodule

// File: tb/tb_multi_digit_recognizer.sv
// Directed bench for multi_digit_recognizer: glyphs are drawn as masks on scan rows/column.
`timescale 1ns/1ps
module tb_multi_digit_recognizer;

    localparam int ND  = 4;
    localparam int CW  = 12;
    localparam int TOP = 50;
    localparam int BOT = 80;
    localparam int Y1  = 61;   // 50 + (30*3)>>3
    localparam int Y2  = 68;   // 50 + (30*5)>>3

    logic              TFT_VCLK = 1'b0;
    logic              rst_n;
    logic [2:0]        frame_cnt;
    logic [23:0]       i_rgb;
    logic              i_vsync;
    logic              i_de;
    logic [CW-1:0]     hcount;
    logic [CW-1:0]     vcount;
    logic [ND*CW-1:0]  box_l, box_r, box_t, box_b;
    logic [ND*4-1:0]   o_digit_ids;
    logic [ND-1:0]     o_unknown;
    logic              o_valid, o_busy, o_overrun;
`ifdef MDR_FEATURE_DEBUG_EN
    logic [ND*16-1:0]  o_features;
    logic [ND*16-1:0]  feat_seen;
`endif

    int          bl[ND], br[ND], bt[ND], bb[ND], bcx[ND];
    logic [63:0] r1m[ND], r2m[ND], cm[ND];
    int          n_cmp, n_err;
    int          lat, nval, nv2;
    bit          busy1;

    always #5 TFT_VCLK = ~TFT_VCLK;

    always_comb begin
        for (int k = 0; k < ND; k++) begin
            box_l[k*CW +: CW] = 12'(bl[k]);
            box_r[k*CW +: CW] = 12'(br[k]);
            box_t[k*CW +: CW] = 12'(bt[k]);
            box_b[k*CW +: CW] = 12'(bb[k]);
        end
    end

    multi_digit_recognizer #(
        .NUM_DIGITS (4),
        .CW         (12),
        .ROW1_NUM   (3),
        .ROW2_NUM   (5),
        .EVAL_FRAME (1)
    ) dut (
        .TFT_VCLK    (TFT_VCLK),
        .rst_n       (rst_n),
        .frame_cnt   (frame_cnt),
        .i_rgb       (i_rgb),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .hcount      (hcount),
        .vcount      (vcount),
        .box_l       (box_l),
        .box_r       (box_r),
        .box_t       (box_t),
        .box_b       (box_b),
        .o_digit_ids (o_digit_ids),
        .o_unknown   (o_unknown),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
`ifdef MDR_FEATURE_DEBUG_EN
        .o_features  (o_features),
`endif
        .o_overrun   (o_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_boxes();
        for (int k = 0; k < ND; k++) begin
            bl[k] = 0; br[k] = 0; bt[k] = 0; bb[k] = 0; bcx[k] = 0;
            r1m[k] = '0; r2m[k] = '0; cm[k] = '0;
        end
    endtask

    // Row masks are offsets from l; column mask offsets from t, drawn at column cx.
    task automatic set_box(input int k, input int l, input int r, input int d);
        bl[k] = l; br[k] = r; bt[k] = TOP; bb[k] = BOT; bcx[k] = l + (r - l) / 2;
        case (d)
            0:       begin r1m[k] = 64'h3000C; r2m[k] = 64'h3000C; cm[k] = 64'h6000_0003; end
            1:       begin r1m[k] = 64'h30;    r2m[k] = 64'h30;    cm[k] = 64'h7;         end
            7:       begin r1m[k] = 64'hC000;  r2m[k] = 64'h30;    cm[k] = 64'h0600_0003; end
            8:       begin r1m[k] = 64'h3000C; r2m[k] = 64'h3000C; cm[k] = 64'h7000_C003; end
            9:       begin r1m[k] = 64'h3000C; r2m[k] = 64'h30000; cm[k] = 64'h7000_C003; end
            default: begin r1m[k] = '0;        r2m[k] = '0;        cm[k] = '0;            end
        endcase
    endtask

    function automatic bit pix(input int h, input int v);
        for (int k = 0; k < ND; k++) begin
            int off;
            off = h - bl[k];
            if (off >= 0 && off < 64) begin
                if (v == Y1 && r1m[k][off]) return 1'b1;
                if (v == Y2 && r2m[k][off]) return 1'b1;
            end
            if (h == bcx[k] && v >= TOP && (v - TOP) < 64 && cm[k][v - TOP]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic draw_frame();
        for (int v = TOP; v <= BOT; v++) begin
            for (int h = 0; h < 128; h++) begin
                @(negedge TFT_VCLK);
                i_de   = 1'b1;
                hcount = 12'(h);
                vcount = 12'(v);
                i_rgb  = pix(h, v) ? 24'hFFFFFF : 24'h000000;
            end
        end
        @(negedge TFT_VCLK);
        i_de  = 1'b0;
        i_rgb = '0;
    endtask

    // VS rise, then watch 20 cycles; dbl injects a second rise two cycles after the first.
    task automatic vs_frame(input logic [2:0] fc, input bit dbl,
                            output int lat_o, output int nval_o);
        lat_o  = -1;
        nval_o = 0;
        @(negedge TFT_VCLK);
        frame_cnt = fc;
        i_de      = 1'b0;
        i_vsync   = 1'b1;
        @(posedge TFT_VCLK);
        #2 i_vsync = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge TFT_VCLK);
            #1;
            if (n == 1) busy1 = o_busy;
            if (o_valid) begin
                nval_o++;
                if (lat_o < 0) lat_o = n;
`ifdef MDR_FEATURE_DEBUG_EN
                feat_seen = o_features;
`endif
            end
            if (dbl) i_vsync = (n == 1);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; frame_cnt = '0; i_rgb = '0; i_vsync = 1'b0; i_de = 1'b0;
        hcount = '0; vcount = '0;
        clear_boxes();
        repeat (3) @(posedge TFT_VCLK);
        #1;
        chk("rst_ids",     32'(o_digit_ids), 32'hFFFF);
        chk("rst_unknown", 32'(o_unknown),   32'hF);
        chk("rst_valid",   32'(o_valid),     32'h0);
        chk("rst_busy",    32'(o_busy),      32'h0);
        chk("rst_overrun", 32'(o_overrun),   32'h0);
        @(negedge TFT_VCLK);
        rst_n = 1'b1;

        // Single "8" in box 0, others zero-sized.
        set_box(0, 100, 120, 8);
        vs_frame(3'd0, 1'b0, lat, nval);
        chk("s1_latch_novalid", 32'(nval), 32'd0);
        draw_frame();
        vs_frame(3'd1, 1'b0, lat, nval);
        chk("s1_latency", 32'(lat),         32'd6);
        chk("s1_nvalid",  32'(nval),        32'd1);
        chk("s1_busy",    32'(busy1),       32'd1);
        chk("s1_ids",     32'(o_digit_ids), 32'hFFF8);
        chk("s1_unknown", 32'(o_unknown),   32'hE);
        chk("s1_idle",    32'(o_busy),      32'd0);
`ifdef MDR_FEATURE_DEBUG_EN
        chk("s1_feat0", 32'(feat_seen[15:0]), 32'hF322);
`endif

        // Four digits 0,1,7,9.
        clear_boxes();
        set_box(0, 10, 30, 0);
        set_box(1, 40, 60, 1);
        set_box(2, 70, 90, 7);
        set_box(3, 100, 120, 9);
        vs_frame(3'd0, 1'b0, lat, nval);
        draw_frame();
        vs_frame(3'd1, 1'b0, lat, nval);
        chk("s2_nvalid",  32'(nval),        32'd1);
        chk("s2_ids",     32'(o_digit_ids), 32'h9710);
        chk("s2_unknown", 32'(o_unknown),   32'h0);
`ifdef MDR_FEATURE_DEBUG_EN
        chk("s2_feat_lo", feat_seen[31:0],  32'hA111_F222);
        chk("s2_feat_hi", feat_seen[63:32], 32'hD321_6211);
`endif

        // 20 alternating pixels on row y1 saturate x1.
        clear_boxes();
        bl[0] = 0; br[0] = 44; bt[0] = TOP; bb[0] = BOT; bcx[0] = 22;
        r1m[0] = 64'h0000_00AA_AAAA_AAAA;
        vs_frame(3'd0, 1'b0, lat, nval);
        draw_frame();
        vs_frame(3'd1, 1'b0, lat, nval);
        chk("s3_nvalid",  32'(nval),        32'd1);
        chk("s3_ids",     32'(o_digit_ids), 32'hFFFF);
        chk("s3_unknown", 32'(o_unknown),   32'hF);
`ifdef MDR_FEATURE_DEBUG_EN
        chk("s3_feat0", 32'(feat_seen[15:0]), 32'hC0F0);
`endif

        // Box 2 only one pixel wider than its left bound.
        clear_boxes();
        set_box(0, 10, 30, 0);
        set_box(1, 40, 60, 1);
        set_box(2, 70, 71, 255);
        set_box(3, 100, 120, 9);
        vs_frame(3'd0, 1'b0, lat, nval);
        draw_frame();
        vs_frame(3'd1, 1'b0, lat, nval);
        chk("s4_ids",     32'(o_digit_ids), 32'h9F10);
        chk("s4_unknown", 32'(o_unknown),   32'h4);

        // Non-evaluating frame, then an evaluating rise followed by a rise while busy.
        clear_boxes();
        set_box(0, 10, 30, 0);
        set_box(1, 40, 60, 1);
        set_box(2, 70, 90, 7);
        set_box(3, 100, 120, 9);
        vs_frame(3'd2, 1'b0, lat, nval);
        chk("s5_fc2_novalid", 32'(nval),        32'd0);
        chk("s5_fc2_ids",     32'(o_digit_ids), 32'h9F10);
        chk("s5_fc2_busy",    32'(busy1),       32'd0);
        draw_frame();
        vs_frame(3'd1, 1'b1, lat, nv2);
        chk("s5_dbl_nvalid", 32'(nv2),         32'd1);
        chk("s5_dbl_lat",    32'(lat),         32'd6);
        chk("s5_overrun",    32'(o_overrun),   32'd1);
        chk("s5_ids",        32'(o_digit_ids), 32'h9710);
        chk("s5_unknown",    32'(o_unknown),   32'h0);

        // Reset in the middle of CLASS.
        @(negedge TFT_VCLK);
        frame_cnt = 3'd1;
        i_vsync   = 1'b1;
        @(posedge TFT_VCLK);
        #2 i_vsync = 1'b0;
        repeat (3) @(posedge TFT_VCLK);
        #1;
        chk("s6_busy_before", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_ids",     32'(o_digit_ids), 32'hFFFF);
        chk("s6_unknown", 32'(o_unknown),   32'hF);
        chk("s6_busy",    32'(o_busy),      32'd0);
        chk("s6_valid",   32'(o_valid),     32'd0);
        chk("s6_overrun", 32'(o_overrun),   32'd0);
        @(negedge TFT_VCLK);
        rst_n = 1'b1;
        nval = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge TFT_VCLK);
            #1;
            if (o_valid) nval++;
        end
        chk("s6_novalid",   32'(nval),        32'd0);
        chk("s6_ids_after", 32'(o_digit_ids), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
